sensor_frame_rx: RTL and testbench

//  UART RS232 receive stage directly upstream of the bus arbiter FSM. Deserialises 8N1 frames

---
 rtl/sensor_frame_rx.sv | 193 +++++++++++++++++++
 tb/tb_sensor_frame_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_rx.sv
// sensor_frame_rx
//   Receives the two-byte sensor reply (data byte, then CRC-8 byte) from the shared
//   sensor line. Each byte is an 8N1 UART frame. The CRC of the data byte is checked
//   against the second byte, and the result goes to the bus arbiter FSM.
//
//   Parameters
//     CLKS_PER_BIT  clock cycles per UART bit
//     TIMEOUT_BITS  bit-times allowed between the byte 0 stop-bit sample and the byte 1 start edge
//     CRC_POLY      CRC-8 polynomial (MSB-first, init 0, no reflection, no final XOR)
//
//   Ports
//     clock         system clock
//     resetn        asynchronous reset, active-low
//     i_rx          serial line, idle high, asynchronous to clock
//     o_active_rx   high from the byte 0 start detect until the reply completes or aborts
//     o_done_rx     one-cycle pulse; o_data_rx / o_result_crc are valid
//     o_data_rx     received data byte, held until the next o_done_rx
//     o_result_crc  1 = the CRC byte matched the CRC-8 of the data byte
//     o_frame_err   one-cycle pulse: stop bit low, or inter-byte timeout
//     dbg_state     current FSM state, for observation only
//
//   Handshake: o_done_rx and o_frame_err are single-cycle pulses with no back-pressure.
//   The consumer must capture o_data_rx / o_result_crc on o_done_rx, or at any time
//   afterwards before the next o_done_rx. The two pulses never assert in the same cycle.
module sensor_frame_rx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          TIMEOUT_BITS = 20,
  parameter logic [7:0]  CRC_POLY     = 8'h07
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_rx,
  output logic       o_active_rx,
  output logic       o_done_rx,
  output logic [7:0] o_data_rx,
  output logic       o_result_crc,
  output logic       o_frame_err,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]    state;
  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          byte_idx;
  logic [7:0]    shift;
  logic [7:0]    data_reg;
  logic [7:0]    crc_reg;
  logic          rx_fall;

  // A start is recognised only on a high-to-low transition. A line held low
  // (break) therefore cannot restart reception until it has gone high again.
  assign rx_fall   = rx_prev & ~rx_s;
  assign dbg_state = state;

  // CRC-8 of one byte with a zero initial value: load the byte, then do 8 shift/XOR steps.
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev      <= 1'b1;
      state        <= S_IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      byte_idx     <= 1'b0;
      shift        <= '0;
      data_reg     <= '0;
      crc_reg      <= '0;
      o_active_rx  <= 1'b0;
      o_done_rx    <= 1'b0;
      o_data_rx    <= '0;
      o_result_crc <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      rx_meta     <= i_rx;
      rx_s        <= rx_meta;
      rx_prev     <= rx_s;
      o_done_rx   <= 1'b0;
      o_frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          // In IDLE the byte index is always 0, so every start here opens a new reply.
          if (rx_fall) begin
            state       <= S_START;
            clk_cnt     <= '0;
            o_active_rx <= 1'b1;
          end
        end

        S_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            if (rx_s) begin
              // Glitch. Before byte 0, go back to idle. Before byte 1, resume
              // waiting in GAP. The timeout count continues from where it stopped.
              if (byte_idx) begin
                state <= S_GAP;
              end else begin
                state       <= S_IDLE;
                o_active_rx <= 1'b0;
              end
            end else begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              o_frame_err <= 1'b1;
              o_active_rx <= 1'b0;
              byte_idx    <= 1'b0;
              state       <= S_IDLE;
            end else if (!byte_idx) begin
              data_reg <= shift;
              crc_reg  <= crc8(shift);
              byte_idx <= 1'b1;
              tmo_cnt  <= '0;
              state    <= S_GAP;
            end else begin
              o_data_rx    <= data_reg;
              o_result_crc <= (shift == crc_reg);
              o_done_rx    <= 1'b1;
              o_active_rx  <= 1'b0;
              byte_idx     <= 1'b0;
              state        <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (rx_fall) begin
            state   <= S_START;
            clk_cnt <= '0;
          end else if (tmo_cnt == TMO_M1) begin
            o_frame_err <= 1'b1;
            o_active_rx <= 1'b0;
            byte_idx    <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_frame_rx.sv
module tb_sensor_frame_rx;

  localparam int CPB = 8;
  localparam int TOB = 4;
  localparam int W   = 42;  // {is_done, data[7:0], crc_ok, exp_cyc[31:0]}

  // ---------------- clock / reset ----------------
  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       i_rx   = 1'b1;
  logic       o_active_rx, o_done_rx, o_result_crc, o_frame_err;
  logic [7:0] o_data_rx;
  logic [2:0] dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sensor_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB), .CRC_POLY(8'h07)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .i_rx         (i_rx),
    .o_active_rx  (o_active_rx),
    .o_done_rx    (o_done_rx),
    .o_data_rx    (o_data_rx),
    .o_result_crc (o_result_crc),
    .o_frame_err  (o_frame_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [7:0] held_data = 8'h00;
  logic       held_crc  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // CRC as the remainder of d(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    end
    return r[7:0];
  endfunction

  task automatic push_done(input logic [7:0] d0, input logic [7:0] d1);
    held_data = d0;
    held_crc  = (d1 == ref_crc(d0));
    exp_q.push_back({1'b1, d0, held_crc, 32'hFFFF_FFFF});
  endtask

  task automatic push_err(input int c);
    exp_q.push_back({1'b0, held_data, held_crc, 32'(c)});
  endtask

  logic [W-1:0] e;
  always @(negedge clock) begin
    if (resetn && (o_done_rx || o_frame_err)) begin
      check("done_err_exclusive", 64'(o_done_rx & o_frame_err), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {62'd0, o_done_rx, o_frame_err}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 64'(o_done_rx), 64'(e[41]));
        check("data", 64'(o_data_rx), 64'(e[40:33]));
        check("result_crc", 64'(o_result_crc), 64'(e[32]));
        check("active_drop", 64'(o_active_rx), 64'd0);
        if (e[31:0] != 32'hFFFF_FFFF) check("timeout_cycle", 64'(cyc), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clock);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    i_rx = stop_ok;
    repeat (CPB) @(negedge clock);
    i_rx = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] d0, d1;
  int r;

  initial begin
    #1;
    check("rst_active", 64'(o_active_rx), 64'd0);
    check("rst_done", 64'(o_done_rx), 64'd0);
    check("rst_data", 64'(o_data_rx), 64'd0);
    check("rst_crc", 64'(o_result_crc), 64'd0);
    check("rst_err", 64'(o_frame_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    idle(10);

    // 1: valid reply 0x01 / 0x07
    send_byte(8'h01, 1'b1);
    check("active_in_gap", 64'(o_active_rx), 64'd1);
    push_done(8'h01, 8'h07);
    send_byte(8'h07, 1'b1);
    idle(10);

    // 2: 0xFF / 0xF3 good, then 0xFF / 0x00 bad
    send_byte(8'hFF, 1'b1);
    push_done(8'hFF, 8'hF3);
    send_byte(8'hF3, 1'b1);
    idle(10);
    send_byte(8'hFF, 1'b1);
    push_done(8'hFF, 8'h00);
    send_byte(8'h00, 1'b1);
    idle(10);

    // 3: byte 0 stop bit low -> frame error, data held
    push_err(-1);
    send_byte(8'h5A, 1'b0);
    idle(10);
    check("active_after_stop_err", 64'(o_active_rx), 64'd0);

    // 4: byte 0 only -> timeout 32 cycles into GAP (111 cycles after the start edge is driven)
    push_err(cyc + 1 + 111);
    send_byte(8'h01, 1'b1);
    idle(60);
    check("idle_after_timeout", 64'(dbg_state), 64'd0);

    // 5: two-cycle low glitch -> no pulses, back to IDLE
    i_rx = 1'b0;
    repeat (2) @(negedge clock);
    idle(20);
    check("glitch_state", 64'(dbg_state), 64'd0);
    check("glitch_active", 64'(o_active_rx), 64'd0);

    // break: line held low -> exactly one frame error, no restart until high
    push_err(-1);
    i_rx = 1'b0;
    repeat (200) @(negedge clock);
    check("break_state_idle", 64'(dbg_state), 64'd0);
    idle(30);

    // 6: reset in the middle of byte 1
    send_byte(8'h33, 1'b1);
    @(negedge clock);
    i_rx = 1'b0;
    repeat (20) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_active", 64'(o_active_rx), 64'd0);
    check("midrst_data", 64'(o_data_rx), 64'd0);
    held_data = 8'h00;
    held_crc  = 1'b0;
    i_rx = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    idle(20);
    send_byte(8'h00, 1'b1);
    push_done(8'h00, 8'h00);
    send_byte(8'h00, 1'b1);
    idle(10);

    // randomized replies
    for (int n = 0; n < 30; n++) begin
      d0 = 8'($urandom_range(0, 255));
      r  = $urandom_range(0, 99);
      d1 = (r < 50) ? ref_crc(d0) : 8'($urandom_range(0, 255));
      if (r >= 85 && r < 93) begin
        push_err(-1);
        send_byte(d0, 1'b0);
      end else if (r >= 93) begin
        send_byte(d0, 1'b1);
        push_err(-1);
        send_byte(d1, 1'b0);
      end else begin
        send_byte(d0, 1'b1);
        idle($urandom_range(0, 2 * CPB));
        push_done(d0, d1);
        send_byte(d1, 1'b1);
      end
      idle(2 * CPB + $urandom_range(0, 5));
    end

    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
